// File: rtl/idct8x8_decoder.sv
// 8x8 inverse DCT: row-then-column separable transform on one time-shared MAC.
// Optional macro IDCT_SAT_EN: saturate column results to [-512,511] instead of wrapping.
module idct8x8_decoder (
  input  logic              clk,
  input  logic              rst,
  input  logic              enin,
  input  logic              enout,
  input  logic signed [9:0] datain,
  output logic signed [9:0] dataout,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {S_LOAD, S_ROW, S_COL, S_OUT} state_t;

  state_t             state_q;
  logic [5:0]         idx_q, ridx_q;
  logic [9:0]         step_q;
  logic signed [27:0] acc_q;

  logic signed [9:0]  cbuf [64];
  logic signed [15:0] tmp  [64];
  logic signed [9:0]  pbuf [64];

  // C[k][n] in Q8; (2n+1)k mod 32 folds onto the first-quadrant cosine table
  function automatic logic signed [8:0] coef(input logic [2:0] k, input logic [2:0] n);
    logic [4:0]        f;
    logic [2:0]        m;
    logic              neg;
    logic signed [8:0] mag;
    f = 5'({3'b0, n, 1'b1} * {4'b0, k});
    case (f[4:3])
      2'd0:    begin m = f[2:0];           neg = 1'b0; end
      2'd1:    begin m = 3'(5'd16 - f);    neg = 1'b1; end
      2'd2:    begin m = f[2:0];           neg = 1'b1; end
      default: begin m = 3'(5'd0 - f);     neg = 1'b0; end
    endcase
    case (m)
      3'd1:    mag = 9'sd126;
      3'd2:    mag = 9'sd118;
      3'd3:    mag = 9'sd106;
      3'd4:    mag = 9'sd91;
      3'd5:    mag = 9'sd71;
      3'd6:    mag = 9'sd49;
      3'd7:    mag = 9'sd25;
      default: mag = 9'sd0;
    endcase
    if (k == 3'd0) coef = 9'sd91;
    else           coef = neg ? -mag : mag;
  endfunction

  // step = {hi, mid, k}: ROW hi=r mid=n, COL hi=m mid=c; k is the summation index
  logic [2:0]         k, mid, hi;
  logic signed [15:0] opa;
  logic signed [8:0]  cf;
  logic signed [24:0] prod;
  logic signed [27:0] sum, rnd;
  logic signed [9:0]  col_res;

  assign k   = step_q[2:0];
  assign mid = step_q[5:3];
  assign hi  = step_q[8:6];

  always_comb begin
    opa = {{6{cbuf[{hi, k}][9]}}, cbuf[{hi, k}]};
    cf  = coef(k, mid);
    if (state_q == S_COL) begin
      opa = tmp[{k, mid}];
      cf  = coef(k, hi);
    end
    prod = opa * cf;
    // Row sums never exceed 22 bits, so the shared 28-bit accumulator is exact for both passes
    sum  = (k == 3'd0 ? 28'sd0 : acc_q) + 28'(prod);
    rnd  = (sum + 28'sd128) >>> 8;
`ifdef IDCT_SAT_EN
    if (rnd > 28'sd511)       col_res = 10'sd511;
    else if (rnd < -28'sd512) col_res = -10'sd512;
    else                      col_res = rnd[9:0];
`else
    col_res = rnd[9:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && enin)                   cbuf[idx_q]     <= datain;
    if (state_q == S_ROW && k == 3'd7)               tmp[{hi, mid}]  <= rnd[15:0];
    if (state_q == S_COL && !step_q[9] && k == 3'd7) pbuf[{hi, mid}] <= col_res;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD;
      idx_q   <= 6'd0;
      ridx_q  <= 6'd0;
      step_q  <= 10'd0;
      acc_q   <= 28'sd0;
      dataout <= 10'sd0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: if (enin) begin
          idx_q <= idx_q + 6'd1;
          if (idx_q == 6'd63) begin
            state_q <= S_ROW;
            busy    <= 1'b1;
            step_q  <= 10'd0;
          end
        end
        S_ROW: begin
          acc_q  <= sum;
          step_q <= step_q + 10'd1;
          if (step_q == 10'd511) begin
            state_q <= S_COL;
            step_q  <= 10'd0;
          end
        end
        // one extra edge after the last product lets the final pbuf write land
        S_COL: if (step_q[9]) begin
          state_q <= S_OUT;
          busy    <= 1'b0;
          done    <= 1'b1;
        end else begin
          acc_q  <= sum;
          step_q <= step_q + 10'd1;
        end
        default: if (enout) begin
          dataout <= pbuf[ridx_q];
          ridx_q  <= ridx_q + 6'd1;
          if (ridx_q == 6'd63) begin
            done    <= 1'b0;
            idx_q   <= 6'd0;
            ridx_q  <= 6'd0;
            state_q <= S_LOAD;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_idct8x8_decoder.sv
// Randomized self-checking bench for idct8x8_decoder against a real-valued-table matrix model.
module tb_idct8x8_decoder;
  logic              clk = 1'b0;
  logic              rst, enin, enout;
  logic signed [9:0] datain, dataout;
  logic              busy, done;

  int checks = 0;
  int errors = 0;
  int ctab [8][8];
  int cin  [64];
  int expv [64];

  always #5 clk = ~clk;

  idct8x8_decoder dut (
    .clk(clk), .rst(rst), .enin(enin), .enout(enout),
    .datain(datain), .dataout(dataout), .busy(busy), .done(done)
  );

  function automatic void build_ctab();
    real v;
    for (int kk = 0; kk < 8; kk++)
      for (int nn = 0; nn < 8; nn++) begin
        if (kk == 0) ctab[kk][nn] = 91;
        else begin
          v = 128.0 * $cos((2.0 * nn + 1.0) * kk * 3.14159265358979 / 16.0);
          ctab[kk][nn] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
        end
      end
  endfunction

  // Separable IDCT as two plain matrix products
  function automatic void model();
    int t [64];
    int s, w;
    for (int r = 0; r < 8; r++)
      for (int n = 0; n < 8; n++) begin
        s = 0;
        for (int kk = 0; kk < 8; kk++) s += cin[r*8+kk] * ctab[kk][n];
        t[r*8+n] = int'(shortint'((s + 128) >>> 8));
      end
    for (int m = 0; m < 8; m++)
      for (int c = 0; c < 8; c++) begin
        s = 0;
        for (int kk = 0; kk < 8; kk++) s += ctab[kk][m] * t[kk*8+c];
        s = (s + 128) >>> 8;
`ifdef IDCT_SAT_EN
        w = (s > 511) ? 511 : (s < -512) ? -512 : s;
`else
        w = s & 1023;
        if (w > 511) w -= 1024;
`endif
        expv[m*8+c] = w;
      end
  endfunction

  task automatic load_block(input int extra, input bit eo);
    int cnt;
    for (int i = 0; i < 64; i++) begin
      enin = 1'b1; enout = eo; datain = 10'(cin[i]);
      @(posedge clk); #1;
      if (eo) begin
        checks++;
        if (dataout !== 10'sd0) begin errors++; $display("FAIL dataout_load got %0d exp 0", dataout); end
      end
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_rise got %b exp 1", busy); end
    cnt = 0;
    while (done !== 1'b1 && cnt < 2000) begin
      enin = (cnt < extra); datain = 10'($urandom);
      @(posedge clk); #1;
      cnt++;
      if (eo) begin
        checks++;
        if (dataout !== 10'sd0) begin errors++; $display("FAIL dataout_busy got %0d exp 0", dataout); end
      end
    end
    enin = 1'b0;
    checks++;
    if (cnt != 1025) begin errors++; $display("FAIL done_latency got %0d exp 1025", cnt); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_fall got %b exp 0", busy); end
  endtask

  task automatic read_block(input bit gaps);
    logic signed [9:0] prev;
    for (int p = 0; p < 64; p++) begin
      if (gaps) begin
        enout = 1'b0; enin = 1'($urandom); datain = 10'($urandom); prev = dataout;
        @(posedge clk); #1;
        checks++;
        if (dataout !== prev) begin errors++; $display("FAIL hold_gap[%0d] got %0d exp %0d", p, dataout, prev); end
      end
      enout = 1'b1; enin = 1'($urandom); datain = 10'($urandom);
      @(posedge clk); #1;
      checks++;
      if (dataout !== 10'(expv[p])) begin
        errors++; $display("FAIL pixel[%0d] got %0d exp %0d", p, dataout, expv[p]);
      end
    end
    enout = 1'b0; enin = 1'b0;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_clear got %b exp 0", done); end
  endtask

  task automatic fill_dc(input int dc, input int pix);
    for (int i = 0; i < 64; i++) begin cin[i] = 0; expv[i] = pix; end
    cin[0] = dc;
  endtask

  task automatic test_reset();
    rst = 1'b1; enin = 1'b0; enout = 1'b0; datain = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dataout !== 10'sd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset got dataout=%0d busy=%b done=%b exp 0/0/0", dataout, busy, done);
    end
    rst = 1'b0;
  endtask

  task automatic test_dc64();
    fill_dc(64, 8); load_block(0, 1'b0); read_block(1'b0);
  endtask

  task automatic test_dc511();
    fill_dc(511, 65); load_block(0, 1'b0); read_block(1'b1);
  endtask

  task automatic test_zero_extra();
    fill_dc(0, 0); load_block(2, 1'b0); read_block(1'b0);
  endtask

  task automatic test_random();
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 64; i++) cin[i] = $urandom_range(0, 1023) - 512;
      model(); load_block(b, 1'b0); read_block(b[0]);
    end
  endtask

  task automatic test_all511();
    for (int i = 0; i < 64; i++) cin[i] = 511;
    model();
`ifdef IDCT_SAT_EN
    expv[0] = 511;
`endif
    load_block(0, 1'b0); read_block(1'b0);
  endtask

  task automatic test_rst_col();
    fill_dc(64, 8);
    for (int i = 0; i < 64; i++) begin
      enin = 1'b1; datain = 10'(cin[i]); @(posedge clk); #1;
    end
    enin = 1'b0;
    repeat (600) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0 || dataout !== 10'sd0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_col got done=%b dataout=%0d busy=%b exp 0/0/0", done, dataout, busy);
    end
    @(posedge clk); #1 rst = 1'b0;
    load_block(0, 1'b1); read_block(1'b1);
  endtask

  initial begin
    build_ctab();
    test_reset();
    test_dc64();
    test_dc511();
    test_zero_extra();
    test_random();
    test_all511();
    test_rst_col();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/idct8x8_decoder.md
# idct8x8_decoder

Inverse 2-D 8×8 DCT block: the decoder counterpart to the `top` DCT encoder. It accepts 64 signed frequency-domain coefficients in raster order on the same `enin`/`datain` streaming convention the encoder uses for pixels. It reconstructs the pixel block with a row-then-column separable IDCT using a single time-shared MAC, and streams the 64 pixels back out under `enout`. It sits at the receive end of the codec path and is used for encoder/decoder round-trip checks.

## Interface
- No parameters; the block is fixed at 8×8 with 10-bit samples.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `enin` input 1: coefficient load strobe; one sample per cycle while high.
- `enout` input 1: pixel read strobe; one sample per cycle while high.
- `datain` input 10 signed: coefficient X[u][v], raster order (u = row, v = col).
- `dataout` output 10 signed: reconstructed pixel, registered.
- `busy` output 1: high from the 64th load edge until `done`.
- `done` output 1: result buffer valid and readable.

## Operation
- States: LOAD → ROW → COL → OUT → LOAD.
- LOAD:
  - Each rising edge with `enin`=1 writes `datain` to `cbuf[idx]` and increments `idx`.
  - On the edge capturing index 63, go to ROW and set `busy`=1.
  - `enin` is ignored in every state except LOAD, so extra samples are dropped.
- Coefficient table C[k][n], 9-bit signed Q8:
  - k=0: 91.
  - k≥1: round(128·cos((2n+1)kπ/16)), rounded half away from zero.
  - Magnitude set: 126, 118, 106, 91, 71, 49, 25.
- ROW (512 cycles): tmp[r][n] = (Σk cbuf[r][k]·C[k][n] + 128) >>> 8.
  - One product per cycle, 22-bit accumulator, stored as 16-bit signed.
- COL (512 cycles): y[m][c] = (Σk C[k][m]·tmp[k][c] + 128) >>> 8.
  - 28-bit accumulator.
  - Result reduced to 10 bits per Configuration, then written to `pbuf`.
- COL → OUT: `busy`=0, `done`=1.
- OUT:
  - Each edge with `enout`=1 drives `dataout` ← `pbuf[ridx]` and increments `ridx`.
  - After index 63 is driven, clear `done`, reset `idx`/`ridx` to 0, and return to LOAD.
  - `dataout` holds its last value.
- `enout` outside OUT is ignored; `dataout` holds.
- `enin` during OUT is ignored; a new block loads only after readout completes.

## Timing
- Reset values: `dataout`=0, `busy`=0, `done`=0, state LOAD, `idx`=`ridx`=0. Buffer contents are don't-care.
- `rst` asserted mid-block in any state aborts immediately and returns to the reset state. No partial output is produced.
- `busy` rises on the same edge that captures coefficient 63.
- `done` rises exactly 1025 edges after that capture edge.
- Read latency:
  - Pixel p[0][0] appears on `dataout` after the first `enout`=1 edge in OUT.
  - Pixel k appears after the (k+1)-th such edge.
  - Gaps in `enout` stall readout without loss.
- `enout` and `enin` both high in LOAD: the load proceeds and `enout` is ignored.

## Configuration
- `IDCT_SAT_EN` defined: the COL result saturates to [-512, 511].
- `IDCT_SAT_EN` undefined: the COL result wraps (its low 10 bits are kept). ROW behaviour is identical in both builds.

## Test plan
- X[0][0]=64, all other coefficients 0 → all 64 pixels = 8; `done` rises 1025 cycles after the last load edge.
- X[0][0]=511, others 0 → all pixels = 65.
- All coefficients 0, with 66 `enin` cycles (encoder-style) → 64 zeros; the 2 extra samples are ignored and the next block loads cleanly.
- All 64 coefficients = 511:
  - With `IDCT_SAT_EN`, p[0][0] = 511.
  - Without it, p[0][0] equals the low 10 bits of the bench model's unsaturated value.
- `rst` pulsed during COL, then a DC=64 block loaded → `done`=0 and `dataout`=0 immediately after reset; the next block reads out all 8s.
- `enout` high while `busy`, then `enout` toggled 1/0 during OUT → `dataout` stays at its reset value until OUT; the readout order is unchanged and no pixel is skipped.
